pcie_tl_state_machine_n: RTL and testbench

Parametrised control state machine for the PCIe transaction layer.
- Supervises NUM_CH virtual-channel FIFOs.
- Captures the low/high flow-control thresholds (umbrales) during an init window and publishes them to the FIFOs.
- Reports idle when every FIFO is empty and latches per-channel FIFO errors into a sticky ERROR state.
- Successor to the fixed 8-channel, 3-bit-threshold controller: channel count and threshold width are parametrised, and threshold validation and error capture are new.

---
 rtl/pcie_tl_state_machine_n.sv | 136 +++++++++++++
 tb/tb_pcie_tl_state_machine_n.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pcie_tl_state_machine_n.sv
`default_nettype none
// ============================================================================
// pcie_tl_state_machine_n : PCIe TL control FSM (thresholds, idle, errors)
// Optional macro IDLE_HYST_EN adds ACTIVE->IDLE hysteresis. Rev 1.0
// ============================================================================
module pcie_tl_state_machine_n #(
    parameter int NUM_CH      = 8,
    parameter int UMBRAL_W    = 3,
    parameter int IDLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                init,
    input  logic [UMBRAL_W-1:0] umbral_bajo_in,
    input  logic [UMBRAL_W-1:0] umbral_alto_in,
    input  logic [NUM_CH-1:0]   empty,
    input  logic [NUM_CH-1:0]   fifo_error,
    output logic [4:0]          state,
    output logic [UMBRAL_W-1:0] umbral_bajo,
    output logic [UMBRAL_W-1:0] umbral_alto,
    output logic                idle,
    output logic                error_out,
    output logic [NUM_CH-1:0]   error_ch
);

    typedef enum logic [4:0] {
        S_RESET  = 5'b00001,
        S_INIT   = 5'b00010,
        S_IDLE   = 5'b00100,
        S_ACTIVE = 5'b01000,
        S_ERROR  = 5'b10000
    } state_t;

    state_t              state_q, state_d;
    logic [UMBRAL_W-1:0] bajo_q, bajo_d;
    logic [UMBRAL_W-1:0] alto_q, alto_d;
    logic [NUM_CH-1:0]   err_ch_q, err_ch_d;

    logic all_empty;
    logic any_err;
    logic to_idle;

    assign all_empty = &empty;
    assign any_err   = |fifo_error;

`ifdef IDLE_HYST_EN
    localparam int CNT_W = $clog2(IDLE_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter only runs while ACTIVE with every FIFO empty; anything else clears it.
    always_comb begin
        cnt_d   = '0;
        to_idle = 1'b0;
        if (state_q == S_ACTIVE && !any_err && !init && all_empty) begin
            if (cnt_q == CNT_W'(IDLE_CYCLES - 1)) begin
                to_idle = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign to_idle = all_empty;
`endif

    always_comb begin
        state_d  = state_q;
        bajo_d   = bajo_q;
        alto_d   = alto_q;
        err_ch_d = err_ch_q;
        case (state_q)
            S_RESET: state_d = S_INIT;
            S_INIT: begin
                bajo_d = umbral_bajo_in;
                alto_d = umbral_alto_in;
                if (!init) begin
                    state_d = (umbral_bajo_in < umbral_alto_in) ? S_IDLE : S_ERROR;
                end
            end
            S_IDLE: begin
                if (any_err) begin
                    state_d  = S_ERROR;
                    err_ch_d = err_ch_q | fifo_error;
                end else if (init) begin
                    state_d = S_INIT;
                end else if (!all_empty) begin
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (any_err) begin
                    state_d  = S_ERROR;
                    err_ch_d = err_ch_q | fifo_error;
                end else if (init) begin
                    state_d = S_INIT;
                end else if (to_idle) begin
                    state_d = S_IDLE;
                end
            end
            // Sticky until reset; keeps accumulating channel errors.
            S_ERROR: err_ch_d = err_ch_q | fifo_error;
            default: state_d = S_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_RESET;
            bajo_q   <= '0;
            alto_q   <= '0;
            err_ch_q <= '0;
        end else begin
            state_q  <= state_d;
            bajo_q   <= bajo_d;
            alto_q   <= alto_d;
            err_ch_q <= err_ch_d;
        end
    end

    assign state       = state_q;
    assign umbral_bajo = bajo_q;
    assign umbral_alto = alto_q;
    assign idle        = (state_q == S_IDLE);
    assign error_out   = (state_q == S_ERROR);
    assign error_ch    = err_ch_q;

endmodule
`default_nettype wire

// File: tb/tb_pcie_tl_state_machine_n.sv
`default_nettype none
// ============================================================================
// tb_pcie_tl_state_machine_n : directed checks on an 8-channel/3-bit and a
// 1-channel/5-bit instance. Rev 1.0
// ============================================================================
module tb_pcie_tl_state_machine_n;

    localparam logic [4:0] ST_RESET  = 5'b00001;
    localparam logic [4:0] ST_INIT   = 5'b00010;
    localparam logic [4:0] ST_IDLE   = 5'b00100;
    localparam logic [4:0] ST_ACTIVE = 5'b01000;
    localparam logic [4:0] ST_ERROR  = 5'b10000;
`ifdef IDLE_HYST_EN
    localparam int HYST = 1;
`else
    localparam int HYST = 0;
`endif

    logic       clk = 1'b0;
    logic       reset, init;
    logic [2:0] bajo_in, alto_in;
    logic [7:0] empty, fifo_error;
    logic [4:0] state;
    logic [2:0] bajo, alto;
    logic       idle, error_out;
    logic [7:0] error_ch;

    logic       reset1, init1;
    logic [4:0] bajo_in1, alto_in1;
    logic [0:0] empty1, fifo_error1;
    logic [4:0] state1;
    logic [4:0] bajo1, alto1;
    logic       idle1, error_out1;
    logic [0:0] error_ch1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pcie_tl_state_machine_n #(.NUM_CH(8), .UMBRAL_W(3), .IDLE_CYCLES(4)) u_dut (
        .clk(clk), .reset(reset), .init(init),
        .umbral_bajo_in(bajo_in), .umbral_alto_in(alto_in),
        .empty(empty), .fifo_error(fifo_error),
        .state(state), .umbral_bajo(bajo), .umbral_alto(alto),
        .idle(idle), .error_out(error_out), .error_ch(error_ch)
    );

    pcie_tl_state_machine_n #(.NUM_CH(1), .UMBRAL_W(5), .IDLE_CYCLES(4)) u_dut1 (
        .clk(clk), .reset(reset1), .init(init1),
        .umbral_bajo_in(bajo_in1), .umbral_alto_in(alto_in1),
        .empty(empty1), .fifo_error(fifo_error1),
        .state(state1), .umbral_bajo(bajo1), .umbral_alto(alto1),
        .idle(idle1), .error_out(error_out1), .error_ch(error_ch1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0; init = 1'b0; bajo_in = '0; alto_in = '0;
        empty = '0; fifo_error = '0;
        reset1 = 1'b0; init1 = 1'b0; bajo_in1 = '0; alto_in1 = '0;
        empty1 = '0; fifo_error1 = '0;

        // Reset held for 4 clocks
        repeat (4) tick();
        chk("rst_state", 32'(state), 32'(ST_RESET));
        chk("rst_bajo", 32'(bajo), 0);
        chk("rst_alto", 32'(alto), 0);
        chk("rst_idle", 32'(idle), 0);
        chk("rst_err", 32'(error_out), 0);
        chk("rst_errch", 32'(error_ch), 0);

        // Bring-up: RESET -> INIT -> IDLE -> ACTIVE with thresholds 1/7
        reset = 1'b1; init = 1'b1; bajo_in = 3'd1; alto_in = 3'd7;
        tick();
        chk("bring_init", 32'(state), 32'(ST_INIT));
        init = 1'b0;
        tick();
        chk("bring_idle", 32'(state), 32'(ST_IDLE));
        chk("bring_idle_o", 32'(idle), 1);
        chk("bring_bajo", 32'(bajo), 1);
        chk("bring_alto", 32'(alto), 7);
        tick();
        chk("bring_active", 32'(state), 32'(ST_ACTIVE));
        chk("bring_idle0", 32'(idle), 0);

        // Fill empty flags one per clock
        for (int i = 0; i < 8; i++) begin
            empty[i] = 1'b1;
            tick();
            chk($sformatf("fill_%0d", i), 32'(state),
                (i == 7 && HYST == 0) ? 32'(ST_IDLE) : 32'(ST_ACTIVE));
        end
`ifdef IDLE_HYST_EN
        tick();
        chk("hyst_cnt2", 32'(state), 32'(ST_ACTIVE));
        empty = 8'hFE;
        tick();
        chk("hyst_drop", 32'(state), 32'(ST_ACTIVE));
        empty = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("hyst_wait_%0d", i), 32'(state), 32'(ST_ACTIVE));
        end
        tick();
        chk("hyst_idle", 32'(state), 32'(ST_IDLE));
`endif
        chk("fill_idle_o", 32'(idle), 1);

        // Error beats init in ACTIVE; error mask accumulates
        empty = 8'h00;
        tick();
        chk("reactivate", 32'(state), 32'(ST_ACTIVE));
        fifo_error = 8'h04; init = 1'b1;
        tick();
        chk("err_prio", 32'(state), 32'(ST_ERROR));
        chk("err_out", 32'(error_out), 1);
        chk("err_ch04", 32'(error_ch), 32'h04);
        fifo_error = 8'h00;
        tick();
        chk("err_sticky", 32'(state), 32'(ST_ERROR));
        init = 1'b0; fifo_error = 8'h80;
        tick();
        chk("err_ch84", 32'(error_ch), 32'h84);
        fifo_error = 8'h00;

        // Re-init to 2/6, reach ACTIVE, then async reset mid-cycle
        reset = 1'b0;
        tick();
        reset = 1'b1; init = 1'b1; bajo_in = 3'd2; alto_in = 3'd6;
        tick();
        tick();
        init = 1'b0;
        tick();
        chk("th26_idle", 32'(state), 32'(ST_IDLE));
        chk("th26_bajo", 32'(bajo), 2);
        chk("th26_alto", 32'(alto), 6);
        tick();
        chk("th26_active", 32'(state), 32'(ST_ACTIVE));
        #2 reset = 1'b0;
        #1;
        chk("async_state", 32'(state), 32'(ST_RESET));
        chk("async_bajo", 32'(bajo), 0);
        chk("async_alto", 32'(alto), 0);
        chk("async_errch", 32'(error_ch), 0);
        reset = 1'b1; init = 1'b1; bajo_in = 3'd3; alto_in = 3'd6;
        tick();
        chk("reload_init", 32'(state), 32'(ST_INIT));
        tick();
        init = 1'b0;
        tick();
        chk("reload_idle", 32'(state), 32'(ST_IDLE));
        chk("reload_bajo", 32'(bajo), 3);
        chk("reload_alto", 32'(alto), 6);

        // Invalid thresholds 5/5 -> ERROR; fifo_error in INIT is not captured
        init = 1'b1; bajo_in = 3'd5; alto_in = 3'd5;
        tick();
        chk("bad_init", 32'(state), 32'(ST_INIT));
        fifo_error = 8'h11; init = 1'b0;
        tick();
        chk("bad_err", 32'(state), 32'(ST_ERROR));
        chk("bad_err_o", 32'(error_out), 1);
        chk("bad_errch", 32'(error_ch), 0);
        fifo_error = 8'h00; init = 1'b1;
        tick();
        chk("bad_init_ign", 32'(state), 32'(ST_ERROR));
        init = 1'b0;

        // NUM_CH=1, UMBRAL_W=5 instance
        reset1 = 1'b1; init1 = 1'b1; bajo_in1 = 5'd0; alto_in1 = 5'd31; empty1 = 1'b1;
        tick();
        chk("n1_init", 32'(state1), 32'(ST_INIT));
        init1 = 1'b0;
        tick();
        chk("n1_idle", 32'(state1), 32'(ST_IDLE));
        chk("n1_bajo", 32'(bajo1), 0);
        chk("n1_alto", 32'(alto1), 31);
        for (int k = 0; k < 2; k++) begin
            empty1 = 1'b0;
            tick();
            chk($sformatf("n1_act_%0d", k), 32'(state1), 32'(ST_ACTIVE));
            empty1 = 1'b1;
            if (HYST != 0) begin
                repeat (3) tick();
            end
            tick();
            chk($sformatf("n1_idle_%0d", k), 32'(state1), 32'(ST_IDLE));
            chk($sformatf("n1_idleo_%0d", k), 32'(idle1), 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
